// File: rtl/farm_road_detector.sv
// Farm-road loop conditioner: synchronizes and debounces the loop, queues vehicles, drives car-waiting request C.
// Latency: loop_raw rise to car_count/detect_pulse/C update is 3+DEBOUNCE_CYC clk edges.
// Backpressure: none; arrivals past a full queue are dropped and flagged on overflow.
module farm_road_detector #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int CNT_W        = 4,
  parameter int SERVICE_CYC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_raw,
  input  logic [2:0]       light_farm,
  output logic             C,
  output logic [CNT_W-1:0] car_count,
  output logic             detect_pulse,
  output logic             overflow,
  output logic             fault
);

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;

  // Light encodings seen on light_farm
  localparam logic [2:0] LIGHT_G = 3'b001;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_R = 3'b100;

  // Debounce and service limits expressed as "last count before the event"
  localparam logic [7:0]       DB_LAST  = 8'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]       SVC_LAST = 8'(SERVICE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Loop conditioning state
  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             db_prev_q;
  logic [7:0]       dbc_q, dbc_d;

  // Queue / service state
  logic [1:0]       state_q, state_d;
  logic [7:0]       tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             pulse_q, pulse_d;
  logic             ovf_q, ovf_d;
  logic             fault_q, fault_d;

  // Decoded per-cycle conditions
  logic             arrival;
  logic             green;
  logic             legal;
  logic             svc_done;
  logic             cnt_full;

  // Two-flop synchronizer for the asynchronous loop input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= loop_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level toggles only after DEBOUNCE_CYC consecutive disagreeing cycles
  always_comb begin
    db_d  = db_q;
    dbc_d = 8'd0;
    if (sync2_q != db_q) begin
      if (dbc_q == DB_LAST) begin
        db_d  = ~db_q;
        dbc_d = 8'd0;
      end else begin
        dbc_d = dbc_q + 8'd1;
      end
    end
  end

  // Debounce registers; db_prev_q gives a registered rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dbc_q     <= 8'd0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      dbc_q     <= dbc_d;
    end
  end

  assign arrival  = db_q & ~db_prev_q;
  assign green    = (light_farm == LIGHT_G);
  assign legal    = (light_farm == LIGHT_G) || (light_farm == LIGHT_Y) ||
                    (light_farm == LIGHT_R);
  assign cnt_full = (cnt_q == CNT_MAX);
  // One vehicle discharged after a full service period of uninterrupted green
  assign svc_done = (state_q == SERVE) && green && (tmr_q == SVC_LAST) &&
                    (cnt_q != '0);

  // Queue counter: arrival and discharge in the same cycle cancel out
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (arrival && !svc_done) begin
      if (cnt_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (!arrival && svc_done) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Service FSM; leaving green mid-service discards the partial timer
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        tmr_d = 8'd0;
        if (arrival) begin
          state_d = REQ;
        end
      end
      REQ: begin
        tmr_d = 8'd0;
        if (green) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (!green) begin
          state_d = REQ;
          tmr_d   = 8'd0;
        end else if (svc_done) begin
          tmr_d = 8'd0;
          if (cnt_d == '0) begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = 8'd0;
      end
    endcase
  end

  // Output next-state: C tracks the count it is registered alongside
  always_comb begin
    c_d     = (cnt_d != '0);
    pulse_d = arrival;
    fault_d = fault_q | ~legal;
  end

  // Queue, FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= 8'd0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
      fault_q <= fault_d;
    end
  end

  assign C            = c_q;
  assign car_count    = cnt_q;
  assign detect_pulse = pulse_q;
  assign overflow     = ovf_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_farm_road_detector.sv
// Directed bench for farm_road_detector: default instance plus a CNT_W=2 instance for saturation.
// Inputs driven 1 ns after each rising edge; outputs sampled at the same point.
// No flow control on the block; all waits are fixed cycle counts.
module tb_farm_road_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       loop_raw;
  logic [2:0] light_farm;
  logic       C;
  logic [3:0] car_count;
  logic       detect_pulse;
  logic       overflow;
  logic       fault;

  logic       loop2;
  logic [2:0] light2;
  logic       c2;
  logic [1:0] cnt2;
  logic       dp2;
  logic       ov2;
  logic       fault2;

  int n_chk = 0;
  int n_err = 0;
  int dp_n  = 0;
  int dp2_n = 0;
  int base;
  int base2;

  farm_road_detector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .loop_raw     (loop_raw),
    .light_farm   (light_farm),
    .C            (C),
    .car_count    (car_count),
    .detect_pulse (detect_pulse),
    .overflow     (overflow),
    .fault        (fault)
  );

  farm_road_detector #(.CNT_W(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .loop_raw     (loop2),
    .light_farm   (light2),
    .C            (c2),
    .car_count    (cnt2),
    .detect_pulse (dp2),
    .overflow     (ov2),
    .fault        (fault2)
  );

  always #5 clk = ~clk;

  // Tally detect pulses of both instances
  always @(negedge clk) begin
    if (detect_pulse === 1'b1) dp_n++;
    if (dp2 === 1'b1) dp2_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arrive1();
    loop_raw = 1'b1;
    tick(10);
    loop_raw = 1'b0;
    tick(10);
  endtask

  task automatic arrive2();
    loop2 = 1'b1;
    tick(10);
    loop2 = 1'b0;
    tick(10);
  endtask

  initial begin
    rst_n      = 1'b0;
    loop_raw   = 1'b0;
    light_farm = 3'b100;
    loop2      = 1'b0;
    light2     = 3'b100;
    #12;
    chk("rst_C",     32'(C),            0);
    chk("rst_cnt",   32'(car_count),    0);
    chk("rst_dp",    32'(detect_pulse), 0);
    chk("rst_ovf",   32'(overflow),     0);
    chk("rst_fault", 32'(fault),        0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Glitches of 3 cycles never survive a 4-cycle debounce
    base = dp_n;
    repeat (5) begin
      loop_raw = 1'b1;
      tick(3);
      loop_raw = 1'b0;
      tick(3);
    end
    tick(6);
    chk("glitch_dp",  32'(dp_n - base), 0);
    chk("glitch_cnt", 32'(car_count),   0);
    chk("glitch_C",   32'(C),           0);

    // Arrival latency: update lands on edge 7 after the rise
    loop_raw = 1'b1;
    tick(6);
    chk("lat_e6_cnt", 32'(car_count),    0);
    chk("lat_e6_C",   32'(C),            0);
    chk("lat_e6_dp",  32'(detect_pulse), 0);
    tick(1);
    chk("lat_e7_cnt", 32'(car_count),    1);
    chk("lat_e7_C",   32'(C),            1);
    chk("lat_e7_dp",  32'(detect_pulse), 1);
    tick(1);
    chk("lat_e8_dp",  32'(detect_pulse), 0);
    chk("lat_e8_cnt", 32'(car_count),    1);
    loop_raw = 1'b0;
    tick(10);

    // Three arrivals under red, then steady green drains at 8-cycle spacing
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    base = dp_n;
    repeat (3) arrive1();
    chk("q3_cnt", 32'(car_count),   3);
    chk("q3_C",   32'(C),           1);
    chk("q3_dp",  32'(dp_n - base), 3);
    light_farm = 3'b001;
    tick(8);
    chk("drain_e8_cnt",  32'(car_count), 3);
    tick(1);
    chk("drain_e9_cnt",  32'(car_count), 2);
    tick(7);
    chk("drain_e16_cnt", 32'(car_count), 2);
    tick(1);
    chk("drain_e17_cnt", 32'(car_count), 1);
    tick(7);
    chk("drain_e24_C",   32'(C),         1);
    tick(1);
    chk("drain_e25_cnt", 32'(car_count), 0);
    chk("drain_e25_C",   32'(C),         0);
    tick(12);
    chk("no_underflow",  32'(car_count), 0);

    // Interrupted green loses partial service
    light_farm = 3'b100;
    tick(1);
    repeat (2) arrive1();
    chk("part_cnt0", 32'(car_count), 2);
    light_farm = 3'b001;
    tick(5);
    light_farm = 3'b010;
    tick(3);
    chk("part_cnt",  32'(car_count), 2);
    chk("part_C",    32'(C),         1);
    light_farm = 3'b001;
    tick(8);
    chk("part_e8_cnt", 32'(car_count), 2);
    tick(1);
    chk("part_e9_cnt", 32'(car_count), 1);
    light_farm = 3'b100;
    tick(1);

    // CNT_W=2 instance: saturation, coincident arrival+discharge, overflow
    base2 = dp2_n;
    repeat (3) arrive2();
    chk("sat_cnt3", 32'(cnt2), 3);
    chk("sat_ovf0", 32'(ov2),  0);
    light2 = 3'b001;
    tick(2);
    loop2 = 1'b1;
    tick(6);
    chk("coin_pre_cnt", 32'(cnt2), 3);
    chk("coin_pre_dp",  32'(dp2),  0);
    tick(1);
    chk("coin_cnt", 32'(cnt2), 3);
    chk("coin_dp",  32'(dp2),  1);
    chk("coin_ovf", 32'(ov2),  0);
    light2 = 3'b100;
    tick(3);
    loop2 = 1'b0;
    tick(10);
    arrive2();
    chk("ovf_cnt", 32'(cnt2),          3);
    chk("ovf_set", 32'(ov2),           1);
    chk("ovf_C",   32'(c2),            1);
    chk("ovf_dps", 32'(dp2_n - base2), 5);
    chk("ovf2_fault", 32'(fault2),     0);

    // Illegal light encoding sets a sticky fault; async reset clears all
    arrive1();
    chk("f_cnt2",   32'(car_count), 2);
    chk("f_before", 32'(fault),     0);
    light_farm = 3'b011;
    tick(1);
    chk("f_set", 32'(fault), 1);
    light_farm = 3'b100;
    tick(3);
    chk("f_sticky",  32'(fault),     1);
    chk("f_cnt_kept", 32'(car_count), 2);
    rst_n = 1'b0;
    #2;
    chk("arst_C",     32'(C),            0);
    chk("arst_cnt",   32'(car_count),    0);
    chk("arst_dp",    32'(detect_pulse), 0);
    chk("arst_ovf",   32'(overflow),     0);
    chk("arst_fault", 32'(fault),        0);
    chk("arst_ovf2",  32'(ov2),          0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/farm_road_detector.md
Name: farm_road_detector

Overview:
- Producer side of the traffic controller's farm-road sensor input `C`.
- Conditions a raw, bouncy inductive-loop signal from the farm road.
- Counts queued vehicles and drives a clean, registered car-waiting request `C` to traffic_light.
- Watches the controller's `light_farm` output to retire queued vehicles while farm green is shown, and flags illegal light encodings.

Parameters:
- DEBOUNCE_CYC, 4: consecutive synchronized cycles `loop_raw` must hold a new level before the debounced level changes (legal range 1..255).
- CNT_W, 4: width of the vehicle queue counter. It saturates at 2^CNT_W-1.
- SERVICE_CYC, 8: cycles of farm green per vehicle discharged (legal range 1..255).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- loop_raw  in  1  raw loop detector, asynchronous to clk, may bounce.
- light_farm  in  3  farm light from the controller, one-hot: 001=G, 010=Y, 100=R.
- C  out  1  registered car-waiting request to traffic_light.
- car_count  out  CNT_W  current queued-vehicle count.
- detect_pulse  out  1  one-cycle pulse per accepted arrival.
- overflow  out  1  sticky flag: an arrival was dropped at saturation.
- fault  out  1  sticky flag: `light_farm` was seen not one-hot.

Behaviour:
- Reset:
  - Async assert clears everything: sync flops, debounced level, debounce counter, service timer, `car_count`=0, `C`=0, `detect_pulse`=0, `overflow`=0, `fault`=0, state=IDLE.
  - Reset mid-operation discards the queue. There is no recovery of prior count.
  - Deassertion is used as-is; the top level synchronizes it.
- Synchronizer: 2-flop synchronizer on `loop_raw`; `light_farm` is synchronous to clk and is not synchronized.
- Debounce:
  - A counter counts consecutive cycles where the sync output differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYC, the debounced level toggles and the counter clears.
  - Any cycle with sync output equal to the debounced level clears the counter.
- Arrival = rising edge of the debounced level.
  - `car_count` increments; `detect_pulse`=1 for exactly that cycle.
  - At 2^CNT_W-1 the count holds, `overflow` sets, and `detect_pulse` still pulses.
- Latency: if `loop_raw` rises before edge 1, then sync=1 after edge 2, the debounced level rises at edge 2+DEBOUNCE_CYC, and `car_count`/`detect_pulse`/`C` update at edge 3+DEBOUNCE_CYC. With defaults this is edge 7.
- State machine (registered):
  - IDLE: `car_count`==0. `C`=0. An arrival goes to REQ.
  - REQ: `car_count`>0. `C`=1. `light_farm`==001 goes to SERVE; the service timer starts from 0.
  - SERVE:
    - The timer increments each cycle `light_farm`==001.
    - When the timer reaches SERVICE_CYC-1, `car_count` decrements and the timer clears.
    - The decrement that brings the count to 0 moves to IDLE.
    - `light_farm`!=001 with count>0 moves to REQ and clears the timer (partial service is lost).
- `C` is registered: `C` = (next `car_count` != 0). It changes on the same edge as `car_count`.
- Simultaneous arrival and service decrement in one cycle: count unchanged, `detect_pulse`=1, timer clears, state unchanged. At saturation, an arrival plus a decrement is not an overflow.
- Decrement never underflows: it is gated by count>0.
- Fault:
  - Any cycle with `light_farm` not in {001, 010, 100} sets `fault` on the next edge.
  - Queue logic treats any non-001 value as "not green".
  - `fault` and `overflow` clear only on reset.
- Arrivals during farm green are counted normally.

Test Plan:
1. Reset, then `loop_raw`=1 steady (10 ns clk, defaults) -> `C`=0, `car_count`=0 until edge 7 after the rise; then `car_count`=1, `C`=1, `detect_pulse` high 1 cycle.
2. `loop_raw` glitches high 3 cycles, low, repeated 5 times -> no arrival; `C`=0, `detect_pulse` never asserts.
3. Three clean arrivals (high 10 / low 10 cycles each) with `light_farm`=100 -> `car_count`=3, `C`=1. Then `light_farm`=001 held -> count 2, 1, 0 at 8-cycle intervals; `C` falls on the edge count hits 0; state IDLE.
4. Count=2, `light_farm`=001 for 5 cycles then 010 -> count stays 2, `C`=1. Green again -> first decrement after a full 8 cycles.
5. CNT_W=2, 4 arrivals under red -> `car_count`=3 saturated, `overflow`=1, 4 `detect_pulse`s. An arrival on the same cycle as a decrement -> count stays 3, `overflow` unchanged.
6. `light_farm`=011 one cycle -> `fault`=1 next edge and stays 1. Then `rst_n` pulsed low with count=2 -> all outputs 0 immediately, without waiting for a clk edge.
